// File: rtl/clint_smp_pkg.sv
// Shared definitions for the core-local interruptor (CLINT).
// Holds the SiFive-compatible register offsets, the mtimecmp reset value,
// and the address decoder that turns a byte offset into a register region
// plus a hart index.
package clint_smp_pkg;

  localparam logic [15:0] MSIP_BASE      = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE  = 16'h4000;
  localparam logic [15:0] MTIME_LO       = 16'hBFF8;
  localparam logic [15:0] MTIME_HI       = 16'hBFFC;
  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    REG_NONE     = 3'd0,
    REG_MSIP     = 3'd1,
    REG_CMP_LO   = 3'd2,
    REG_CMP_HI   = 3'd3,
    REG_MTIME_LO = 3'd4,
    REG_MTIME_HI = 3'd5
  } region_e;

  typedef struct packed {
    region_e     region;
    logic [11:0] hart;
  } decode_t;

  // The hart index is not range-checked here; the top only matches indices
  // that have an instance, so out-of-range harts read 0 and drop writes.
  function automatic decode_t decode_addr(input logic [15:0] addr);
    decode_t     d;
    logic [15:0] word;
    logic [15:0] msip_off;
    logic [15:0] cmp_off;
    word     = addr & 16'hFFFC;
    msip_off = word - MSIP_BASE;
    cmp_off  = word - MTIMECMP_BASE;
    d.region = REG_NONE;
    d.hart   = 12'd0;
    if (word == MTIME_LO) begin
      d.region = REG_MTIME_LO;
    end else if (word == MTIME_HI) begin
      d.region = REG_MTIME_HI;
    end else if (word < MTIMECMP_BASE) begin
      d.region = REG_MSIP;
      d.hart   = msip_off[13:2];
    end else if (!cmp_off[15]) begin
      // 0x4000..0xBFF7: 8 bytes per hart, bit 2 picks the upper half
      d.region = cmp_off[2] ? REG_CMP_HI : REG_CMP_LO;
      d.hart   = cmp_off[14:3];
    end else begin
      d.region = REG_NONE;
      d.hart   = 12'd0;
    end
    return d;
  endfunction

endpackage

// File: rtl/clint_hart_timer.sv
// Per-hart CLINT state: the 64-bit mtimecmp register, the msip bit and the
// registered timer-pending compare.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   msip_we      write strobe for msip (takes wdata[0])
//   cmp_lo_we    write strobe for mtimecmp[31:0]
//   cmp_hi_we    write strobe for mtimecmp[63:32]
//   wdata        bus write data
//   mtime_next   value mtime takes at this edge
//   mtimecmp     current compare register
//   msip         software interrupt pending
//   mtip         timer interrupt pending (level)
module clint_hart_timer
  import clint_smp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        msip_we,
  input  logic        cmp_lo_we,
  input  logic        cmp_hi_we,
  input  logic [31:0] wdata,
  input  logic [63:0] mtime_next,
  output logic [63:0] mtimecmp,
  output logic        msip,
  output logic        mtip
);

  // Compare and software-interrupt registers; mtip compares the incoming
  // mtime against the compare value held before this edge's write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= MTIMECMP_RESET;
      msip     <= 1'b0;
      mtip     <= 1'b0;
    end else begin
      mtip <= (mtime_next >= mtimecmp);
      if (cmp_lo_we) begin
        mtimecmp[31:0] <= wdata;
      end
      if (cmp_hi_we) begin
        mtimecmp[63:32] <= wdata;
      end
      if (msip_we) begin
        msip <= wdata[0];
      end
    end
  end

endmodule

// File: rtl/clint_smp.sv
// Core-local interruptor for the multi-hart cluster: 64-bit mtime with a
// prescaler, per-hart mtimecmp/msip, single-beat 32-bit MMIO slave.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   w_req      access strobe; w_we selects write (1) or read (0)
//   w_addr     byte offset in the CLINT window (bits 1:0 ignored)
//   w_wdata    write data
//   w_rdata    read data, held until the next read response
//   w_rvalid   one-cycle read response strobe, one cycle after the request
//   w_mtime    current mtime
//   w_mtip     per-hart timer pending
//   w_msip     per-hart software pending
module clint_smp
  import clint_smp_pkg::*;
#(
  parameter int N_HARTS  = 1,
  parameter int TICK_DIV = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               w_req,
  input  logic               w_we,
  input  logic [15:0]        w_addr,
  input  logic [31:0]        w_wdata,
  output logic [31:0]        w_rdata,
  output logic               w_rvalid,
  output logic [63:0]        w_mtime,
  output logic [N_HARTS-1:0] w_mtip,
  output logic [N_HARTS-1:0] w_msip
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  decode_t     dec_s;
  logic        wr_s;
  logic        rd_req_s;
  logic        tick_s;
  logic [PW-1:0] presc_r;
  logic [63:0] mtime_r;
  logic [63:0] mtime_next_s;
  logic [63:0] cmp_s [N_HARTS];
  logic [63:0] sel_cmp_s;
  logic        sel_msip_s;
  logic [31:0] rd_val_s;
  logic [31:0] rdata_r;
  logic        rvalid_r;

  assign dec_s    = decode_addr(w_addr);
  assign wr_s     = w_req && w_we;
  assign rd_req_s = w_req && !w_we;
  assign tick_s   = (presc_r == PRESC_MAX);

  // Prescaler: free-running 0..TICK_DIV-1, untouched by mtime writes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_r <= {PW{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Next mtime: a half-write wins over the tick and leaves the other half
  // as it was, so no increment happens in that cycle.
  always_comb begin
    mtime_next_s = mtime_r;
    if (wr_s && (dec_s.region == REG_MTIME_LO)) begin
      mtime_next_s = {mtime_r[63:32], w_wdata};
    end else if (wr_s && (dec_s.region == REG_MTIME_HI)) begin
      mtime_next_s = {w_wdata, mtime_r[31:0]};
    end else if (tick_s) begin
      mtime_next_s = mtime_r + 64'd1;
    end else begin
      mtime_next_s = mtime_r;
    end
  end

  // mtime register; wraps naturally at 2^64.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mtime_r <= 64'd0;
    end else begin
      mtime_r <= mtime_next_s;
    end
  end

  for (genvar g = 0; g < N_HARTS; g++) begin : g_hart
    logic hit_s;
    assign hit_s = wr_s && (dec_s.hart == 12'(g));
    clint_hart_timer u_timer (
      .clk        (CLK),
      .rst        (RST),
      .msip_we    (hit_s && (dec_s.region == REG_MSIP)),
      .cmp_lo_we  (hit_s && (dec_s.region == REG_CMP_LO)),
      .cmp_hi_we  (hit_s && (dec_s.region == REG_CMP_HI)),
      .wdata      (w_wdata),
      .mtime_next (mtime_next_s),
      .mtimecmp   (cmp_s[g]),
      .msip       (w_msip[g]),
      .mtip       (w_mtip[g])
    );
  end

  // Read mux: pick the addressed hart (none matches -> 0), then the half.
  always_comb begin
    sel_cmp_s  = 64'd0;
    sel_msip_s = 1'b0;
    rd_val_s   = 32'd0;
    for (int i = 0; i < N_HARTS; i++) begin
      sel_cmp_s  = sel_cmp_s | ((dec_s.hart == 12'(i)) ? cmp_s[i] : 64'd0);
      sel_msip_s = sel_msip_s | ((dec_s.hart == 12'(i)) && w_msip[i]);
    end
    case (dec_s.region)
      REG_MSIP:     rd_val_s = {31'd0, sel_msip_s};
      REG_CMP_LO:   rd_val_s = sel_cmp_s[31:0];
      REG_CMP_HI:   rd_val_s = sel_cmp_s[63:32];
      REG_MTIME_LO: rd_val_s = mtime_r[31:0];
      REG_MTIME_HI: rd_val_s = mtime_r[63:32];
      default:      rd_val_s = 32'd0;
    endcase
  end

  // Read response: data captured from pre-edge state, held between reads.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_r  <= 32'd0;
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= rd_req_s;
      if (rd_req_s) begin
        rdata_r <= rd_val_s;
      end
    end
  end

  assign w_rdata  = rdata_r;
  assign w_rvalid = rvalid_r;
  assign w_mtime  = mtime_r;

endmodule

// File: tb/tb_clint_smp.sv
// Self-checking bench for clint_smp: two instances (2 harts / TICK_DIV=1 and
// 3 harts / TICK_DIV=4) on one shared bus, directed scenarios plus random
// traffic checked against a behavioural register-map model.
module tb_clint_smp;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b;
  logic [63:0] mtime_a, mtime_b;
  logic [1:0]  mtip_a, msip_a;
  logic [2:0]  mtip_b, msip_b;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  clint_smp #(.N_HARTS(2), .TICK_DIV(1)) dut_a (
    .CLK(CLK), .RST(RST), .w_req(req), .w_we(we), .w_addr(addr), .w_wdata(wdata),
    .w_rdata(rdata_a), .w_rvalid(rvalid_a), .w_mtime(mtime_a), .w_mtip(mtip_a), .w_msip(msip_a)
  );

  clint_smp #(.N_HARTS(3), .TICK_DIV(4)) dut_b (
    .CLK(CLK), .RST(RST), .w_req(req), .w_we(we), .w_addr(addr), .w_wdata(wdata),
    .w_rdata(rdata_b), .w_rvalid(rvalid_b), .w_mtime(mtime_b), .w_mtip(mtip_b), .w_msip(msip_b)
  );

  // Reference model, index 0 = dut_a, 1 = dut_b
  int              n_h [2] = '{2, 3};
  int              td  [2] = '{1, 4};
  longint unsigned m_mtime [2];
  int              m_presc [2];
  longint unsigned m_cmp   [2][3];
  bit              m_msip  [2][3];
  bit              m_mtip  [2][3];
  bit [31:0]       m_rdata [2];
  bit              m_rvalid[2];

  function automatic bit [31:0] model_read(int k, bit [15:0] a);
    int unsigned     w, h;
    longint unsigned c;
    longint unsigned t;
    w = {16'd0, a} & 32'h0000_FFFC;
    t = m_mtime[k];
    if (w == 32'hBFF8) return t[31:0];
    if (w == 32'hBFFC) return t[63:32];
    if (w >= 32'h4000) begin
      h = (w - 32'h4000) / 8;
      if (h < n_h[k]) begin
        c = m_cmp[k][h];
        return (((w - 32'h4000) % 8) == 4) ? c[63:32] : c[31:0];
      end
      return 32'd0;
    end
    h = w / 4;
    if (h < n_h[k]) return {31'd0, m_msip[k][h]};
    return 32'd0;
  endfunction

  task automatic model_edge(int k, bit r, bit rq, bit w_e, bit [15:0] a, bit [31:0] d);
    bit [31:0]       rd;
    longint unsigned nxt, c;
    int unsigned     wd, h;
    if (r) begin
      m_mtime[k] = 0; m_presc[k] = 0; m_rdata[k] = 0; m_rvalid[k] = 0;
      for (int i = 0; i < 3; i++) begin
        m_cmp[k][i] = 64'hFFFF_FFFF_FFFF_FFFF; m_msip[k][i] = 0; m_mtip[k][i] = 0;
      end
      return;
    end
    rd  = model_read(k, a);
    wd  = {16'd0, a} & 32'h0000_FFFC;
    nxt = m_mtime[k];
    if (rq && w_e && wd == 32'hBFF8) nxt = {nxt[63:32], d};
    else if (rq && w_e && wd == 32'hBFFC) nxt = {d, nxt[31:0]};
    else if (m_presc[k] == td[k] - 1) nxt = nxt + 1;
    m_presc[k] = (m_presc[k] + 1) % td[k];
    for (int i = 0; i < n_h[k]; i++) m_mtip[k][i] = (nxt >= m_cmp[k][i]);
    if (rq && w_e) begin
      if (wd >= 32'h4000 && wd < 32'hBFF8) begin
        h = (wd - 32'h4000) / 8;
        if (h < n_h[k]) begin
          c = m_cmp[k][h];
          if (((wd - 32'h4000) % 8) == 4) c = {d, c[31:0]};
          else c = {c[63:32], d};
          m_cmp[k][h] = c;
        end
      end else if (wd < 32'h4000) begin
        h = wd / 4;
        if (h < n_h[k]) m_msip[k][h] = d[0];
      end
    end
    m_mtime[k]  = nxt;
    m_rvalid[k] = rq && !w_e;
    if (m_rvalid[k]) m_rdata[k] = rd;
  endtask

  // One clock: drive, take the edge (DUT and model), settle 1 time unit after.
  task automatic step(bit r, bit rq, bit w_e, bit [15:0] a, bit [31:0] d);
    RST = r; req = rq; we = w_e; addr = a; wdata = d;
    @(posedge CLK);
    model_edge(0, r, rq, w_e, a, d);
    model_edge(1, r, rq, w_e, a, d);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
  endtask

  task automatic wr(bit [15:0] a, bit [31:0] d);
    step(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(bit [15:0] a);
    step(1'b0, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic test_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0, 16'hBFF8, 32'h0);
    checks++; if (rvalid_a !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", rvalid_a); end
    checks++; if (rdata_a !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata_a); end
    checks++; if (mtime_a !== 64'd0) begin errors++; $display("FAIL rst_mtime got %h exp 0", mtime_a); end
    checks++; if (mtip_a !== 2'b00 || msip_a !== 2'b00) begin errors++; $display("FAIL rst_irq got mtip %b msip %b exp 00 00", mtip_a, msip_a); end
    repeat (10) idle();
    checks++; if (mtime_a !== 64'd10) begin errors++; $display("FAIL idle_mtime_a got %0d exp 10", mtime_a); end
    checks++; if (mtime_b !== 64'd2) begin errors++; $display("FAIL idle_mtime_b got %0d exp 2", mtime_b); end
    checks++; if (mtip_a !== 2'b00 || msip_a !== 2'b00) begin errors++; $display("FAIL idle_irq got mtip %b msip %b exp 00 00", mtip_a, msip_a); end
  endtask

  task automatic test_msip();
    wr(16'h0004, 32'h1);
    checks++; if (msip_a !== 2'b10) begin errors++; $display("FAIL msip_a got %b exp 10", msip_a); end
    checks++; if (msip_b !== 3'b010) begin errors++; $display("FAIL msip_b got %b exp 010", msip_b); end
    rd(16'h0004);
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 32'd1) begin errors++; $display("FAIL msip_read got v%b %h exp v1 1", rvalid_a, rdata_a); end
    idle();
    checks++; if (rvalid_a !== 1'b0 || rdata_a !== 32'd1) begin errors++; $display("FAIL rdata_hold got v%b %h exp v0 1", rvalid_a, rdata_a); end
  endtask

  task automatic test_mtip();
    int n;
    wr(16'h4004, 32'd0);
    wr(16'h4000, 32'd20);
    n = 0;
    while (mtime_a !== 64'd20 && n < 30) begin
      checks++; if (mtip_a[0] !== 1'b0) begin errors++; $display("FAIL mtip_early got %b exp 0 at mtime %0d", mtip_a[0], mtime_a); end
      idle();
      n++;
    end
    checks++; if (mtime_a !== 64'd20) begin errors++; $display("FAIL mtime_reach20 got %0d exp 20", mtime_a); end
    checks++; if (mtip_a !== 2'b01) begin errors++; $display("FAIL mtip_rise got %b exp 01", mtip_a); end
    checks++; if (mtip_b !== 3'b000) begin errors++; $display("FAIL mtip_b_low got %b exp 000", mtip_b); end
    wr(16'h4000, 32'd100);
    checks++; if (mtip_a[0] !== 1'b1) begin errors++; $display("FAIL mtip_latency got %b exp 1", mtip_a[0]); end
    idle();
    checks++; if (mtip_a[0] !== 1'b0) begin errors++; $display("FAIL mtip_drop got %b exp 0", mtip_a[0]); end
  endtask

  task automatic test_mtime_wrap();
    wr(16'hBFF8, 32'hFFFF_FFFF);
    checks++; if (mtime_a !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL mtime_lo_wr got %h exp 00000000ffffffff", mtime_a); end
    wr(16'hBFFC, 32'h0);
    checks++; if (mtime_a !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL mtime_hi_wr got %h exp 00000000ffffffff", mtime_a); end
    idle();
    checks++; if (mtime_a !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL mtime_carry got %h exp 0000000100000000", mtime_a); end
    wr(16'hBFFC, 32'hFFFF_FFFF);
    wr(16'hBFF8, 32'hFFFF_FFFF);
    checks++; if (mtime_a !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mtime_ones got %h exp all ones", mtime_a); end
    checks++; if (mtip_a !== 2'b11) begin errors++; $display("FAIL mtip_ones got %b exp 11", mtip_a); end
    idle();
    checks++; if (mtime_a !== 64'd0) begin errors++; $display("FAIL mtime_wrap got %h exp 0", mtime_a); end
    checks++; if (mtip_a !== 2'b00) begin errors++; $display("FAIL mtip_wrap got %b exp 00", mtip_a); end
    checks++; if (mtime_b !== m_mtime[1]) begin errors++; $display("FAIL mtime_b_wrap got %h exp %h", mtime_b, m_mtime[1]); end
  endtask

  task automatic test_tick_div();
    int n;
    wr(16'hBFFC, 32'h0);
    n = 0;
    while (m_presc[1] != 3 && n < 8) begin idle(); n++; end
    wr(16'hBFF8, 32'h55);
    checks++; if (mtime_b !== 64'h55) begin errors++; $display("FAIL tick_wr got %h exp 55", mtime_b); end
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if (mtime_b !== 64'h55) begin errors++; $display("FAIL tick_hold%0d got %h exp 55", i, mtime_b); end
    end
    idle();
    checks++; if (mtime_b !== 64'h56) begin errors++; $display("FAIL tick_inc got %h exp 56", mtime_b); end
  endtask

  task automatic test_unmapped();
    wr(16'h0008, 32'h1);
    wr(16'h1234, 32'hFFFF_FFFF);
    wr(16'hC000, 32'hFFFF_FFFF);
    checks++; if (msip_a !== 2'b10) begin errors++; $display("FAIL unmapped_msip_a got %b exp 10", msip_a); end
    checks++; if (msip_b !== 3'b110) begin errors++; $display("FAIL hart2_msip_b got %b exp 110", msip_b); end
    rd(16'h0008);
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 32'd0) begin errors++; $display("FAIL hart2_rd_a got v%b %h exp v1 0", rvalid_a, rdata_a); end
    checks++; if (rdata_b !== 32'd1) begin errors++; $display("FAIL hart2_rd_b got %h exp 1", rdata_b); end
    rd(16'h4010);
    checks++; if (rdata_a !== 32'd0 || rdata_b !== 32'hFFFF_FFFF) begin errors++; $display("FAIL hart2_cmp got a %h b %h exp 0 ffffffff", rdata_a, rdata_b); end
    rd(16'h1234);
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 32'd0) begin errors++; $display("FAIL hole_rd got v%b %h exp v1 0", rvalid_a, rdata_a); end
  endtask

  task automatic test_reset_abort();
    step(1'b1, 1'b1, 1'b0, 16'h0004, 32'h0);
    checks++; if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin errors++; $display("FAIL abort_rvalid got %b %b exp 0 0", rvalid_a, rvalid_b); end
    checks++; if (rdata_b !== 32'd0 || mtime_a !== 64'd0) begin errors++; $display("FAIL abort_state got rdata %h mtime %h exp 0 0", rdata_b, mtime_a); end
    checks++; if (msip_a !== 2'b00 || msip_b !== 3'b000 || mtip_a !== 2'b00) begin errors++; $display("FAIL abort_irq got %b %b %b exp zeros", msip_a, msip_b, mtip_a); end
    rd(16'h4004);
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 32'hFFFF_FFFF) begin errors++; $display("FAIL abort_cmp_rst got v%b %h exp v1 ffffffff", rvalid_a, rdata_a); end
  endtask

  task automatic test_random();
    bit [15:0] addrs [13] = '{16'h0000, 16'h0004, 16'h0008, 16'h1234, 16'h4000, 16'h4004,
                              16'h4008, 16'h400C, 16'h4010, 16'h4014, 16'hBFF8, 16'hBFFC, 16'hFFFC};
    bit [15:0] a;
    bit [31:0] d;
    bit [1:0]  ea_t, ea_s;
    bit [2:0]  eb_t, eb_s;
    longint unsigned t;
    for (int c = 0; c < 400; c++) begin
      a = addrs[$urandom_range(0, 12)] | 16'($urandom_range(0, 3));
      t = m_mtime[0];
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = t[31:0] + 32'($urandom_range(0, 30));
        2: d = 32'd0;
        default: d = 32'd1;
      endcase
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, d);
      for (int i = 0; i < 2; i++) begin ea_t[i] = m_mtip[0][i]; ea_s[i] = m_msip[0][i]; end
      for (int i = 0; i < 3; i++) begin eb_t[i] = m_mtip[1][i]; eb_s[i] = m_msip[1][i]; end
      checks++;
      if (rvalid_a !== m_rvalid[0] || rdata_a !== m_rdata[0] || mtime_a !== m_mtime[0] || mtip_a !== ea_t || msip_a !== ea_s) begin
        errors++;
        $display("FAIL rand_a cyc %0d got v%b %h %h %b %b exp v%b %h %h %b %b", c, rvalid_a, rdata_a, mtime_a, mtip_a, msip_a,
                 m_rvalid[0], m_rdata[0], m_mtime[0], ea_t, ea_s);
      end
      checks++;
      if (rvalid_b !== m_rvalid[1] || rdata_b !== m_rdata[1] || mtime_b !== m_mtime[1] || mtip_b !== eb_t || msip_b !== eb_s) begin
        errors++;
        $display("FAIL rand_b cyc %0d got v%b %h %h %b %b exp v%b %h %h %b %b", c, rvalid_b, rdata_b, mtime_b, mtip_b, msip_b,
                 m_rvalid[1], m_rdata[1], m_mtime[1], eb_t, eb_s);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 32'h0;
    test_reset();
    test_msip();
    test_mtip();
    test_mtime_wrap();
    test_tick_div();
    test_unmapped();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
